// File: rtl/ft_error_monitor.sv
// Error-event monitor for a bank of TMR registers: turns voter error levels into edge events,
// counts them with saturation, keeps sticky flags and a first-event capture, and raises an alarm.
module ft_error_monitor #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [N_SRC-1:0]     error1_i,
    input  logic [N_SRC-1:0]     error2_i,
    input  logic [CNT_WIDTH-1:0] thresh_i,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] cnt1_o,
    output logic [CNT_WIDTH-1:0] cnt2_o,
    output logic [N_SRC-1:0]     sticky1_o,
    output logic [N_SRC-1:0]     sticky2_o,
    output logic                 first_valid_o,
    output logic [SRC_W-1:0]     first_src_o,
    output logic                 first_type_o,
    output logic                 irq_o
);

    localparam int unsigned PopW = $clog2(N_SRC + 1);
    localparam int unsigned SumW = CNT_WIDTH + PopW;

    typedef enum logic [1:0] {StIdle, StLogged, StAlarm} state_e;

    state_e               state_q, state_d, state_base;
    logic [N_SRC-1:0]     prev_s_q, prev_d_q;
    logic [N_SRC-1:0]     cur_s, cur_d, ev_s, ev_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [N_SRC-1:0]     sticky1_q, sticky1_d, sticky2_q, sticky2_d;
    logic                 first_valid_q, first_valid_d;
    logic [SRC_W-1:0]     first_src_q, first_src_d;
    logic                 first_type_q, first_type_d;
    logic                 irq_q, irq_d;
    logic [PopW-1:0]      pop1, pop2;
    logic [SumW-1:0]      sum1, sum2;
    logic [SRC_W-1:0]     sel_s, sel_d;
    logic                 any_ev, alarm;

    // Double classification dominates; an s->d or d->s change is a fresh event of the new kind.
    always_comb begin
        cur_d = error2_i;
        cur_s = error1_i & ~error2_i;
        ev_d  = cur_d & ~prev_d_q;
        ev_s  = cur_s & ~prev_s_q;
        any_ev = |{ev_d, ev_s};
    end

    always_comb begin
        pop1 = '0;
        pop2 = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            pop1 = pop1 + PopW'(ev_s[i]);
            pop2 = pop2 + PopW'(ev_d[i]);
        end
    end

    // A clear in the same cycle as events keeps just that cycle's contribution.
    always_comb begin
        sum1 = (clear_i ? SumW'(0) : SumW'(cnt1_q)) + SumW'(pop1);
        sum2 = (clear_i ? SumW'(0) : SumW'(cnt2_q)) + SumW'(pop2);
        cnt1_d = (|sum1[SumW-1:CNT_WIDTH]) ? {CNT_WIDTH{1'b1}} : sum1[CNT_WIDTH-1:0];
        cnt2_d = (|sum2[SumW-1:CNT_WIDTH]) ? {CNT_WIDTH{1'b1}} : sum2[CNT_WIDTH-1:0];
        sticky1_d = (clear_i ? '0 : sticky1_q) | ev_s;
        sticky2_d = (clear_i ? '0 : sticky2_q) | ev_d;
    end

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        sel_s = '0;
        sel_d = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (ev_s[i]) begin
                sel_s = SRC_W'(i);
            end
            if (ev_d[i]) begin
                sel_d = SRC_W'(i);
            end
        end
    end

    always_comb begin
        first_valid_d = clear_i ? 1'b0 : first_valid_q;
        first_src_d   = clear_i ? '0 : first_src_q;
        first_type_d  = clear_i ? 1'b0 : first_type_q;
        if (!first_valid_d && any_ev) begin
            first_valid_d = 1'b1;
            first_type_d  = |ev_d;
            first_src_d   = (|ev_d) ? sel_d : sel_s;
        end
    end

    always_comb begin
        alarm = (cnt2_d != '0) || ((thresh_i != '0) && (cnt1_d >= thresh_i));
        state_base = clear_i ? StIdle : state_q;
        state_d = state_base;
        case (state_base)
            StAlarm: state_d = StAlarm;
            default: begin
                if (alarm) begin
                    state_d = StAlarm;
                end else if (any_ev) begin
                    state_d = StLogged;
                end
            end
        endcase
        irq_d = (state_d == StAlarm);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= StIdle;
            prev_s_q      <= '0;
            prev_d_q      <= '0;
            cnt1_q        <= '0;
            cnt2_q        <= '0;
            sticky1_q     <= '0;
            sticky2_q     <= '0;
            first_valid_q <= 1'b0;
            first_src_q   <= '0;
            first_type_q  <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_s_q      <= cur_s;
            prev_d_q      <= cur_d;
            cnt1_q        <= cnt1_d;
            cnt2_q        <= cnt2_d;
            sticky1_q     <= sticky1_d;
            sticky2_q     <= sticky2_d;
            first_valid_q <= first_valid_d;
            first_src_q   <= first_src_d;
            first_type_q  <= first_type_d;
            irq_q         <= irq_d;
        end
    end

    assign cnt1_o        = cnt1_q;
    assign cnt2_o        = cnt2_q;
    assign sticky1_o     = sticky1_q;
    assign sticky2_o     = sticky2_q;
    assign first_valid_o = first_valid_q;
    assign first_src_o   = first_src_q;
    assign first_type_o  = first_type_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_ft_error_monitor.sv
// Bench for ft_error_monitor: a 16-bit-counter instance for function and a 4-bit-counter
// instance sharing the same stimulus for saturation.
module tb_ft_error_monitor;

    typedef struct packed {
        logic [15:0] cnt1;
        logic [15:0] cnt2;
        logic [3:0]  st1;
        logic [3:0]  st2;
        logic        fv;
        logic [1:0]  fsrc;
        logic        ftype;
        logic        irq;
    } obs_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  e1, e2;
    logic [15:0] thresh;
    logic        clr;

    logic [15:0] cnt1, cnt2;
    logic [3:0]  st1, st2;
    logic        fv, ftype, irq;
    logic [1:0]  fsrc;

    logic [3:0]  s_cnt1, s_cnt2, s_st1, s_st2;
    logic        s_fv, s_ftype, s_irq;
    logic [1:0]  s_fsrc;

    obs_t        q[$];
    logic [3:0]  q_small[$];
    obs_t        obs, exp_v;
    logic [3:0]  s_exp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ft_error_monitor #(.N_SRC(4), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .error1_i(e1), .error2_i(e2), .thresh_i(thresh),
        .clear_i(clr), .cnt1_o(cnt1), .cnt2_o(cnt2), .sticky1_o(st1), .sticky2_o(st2),
        .first_valid_o(fv), .first_src_o(fsrc), .first_type_o(ftype), .irq_o(irq)
    );

    ft_error_monitor #(.N_SRC(4), .CNT_WIDTH(4)) dut_small (
        .clk_i(clk), .rstn_i(rstn), .error1_i(e1), .error2_i(e2), .thresh_i(thresh[3:0]),
        .clear_i(clr), .cnt1_o(s_cnt1), .cnt2_o(s_cnt2), .sticky1_o(s_st1), .sticky2_o(s_st2),
        .first_valid_o(s_fv), .first_src_o(s_fsrc), .first_type_o(s_ftype), .irq_o(s_irq)
    );

    function automatic obs_t mk(input int c1, input int c2, input logic [3:0] s1,
                                input logic [3:0] s2, input logic v, input int src,
                                input logic typ, input logic alarm);
        obs_t o;
        o.cnt1 = 16'(c1);
        o.cnt2 = 16'(c2);
        o.st1 = s1;
        o.st2 = s2;
        o.fv = v;
        o.fsrc = 2'(src);
        o.ftype = typ;
        o.irq = alarm;
        return o;
    endfunction

    function automatic obs_t sample();
        return {cnt1, cnt2, st1, st2, fv, fsrc, ftype, irq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        #1;
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_held got %h want %h", obs, exp_v); end
        @(negedge clk);
        rstn = 1'b1;
        q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_idle got %h want %h", obs, exp_v); end
    endtask

    task automatic test_single_event();
        thresh = 16'd3;
        e1 = 4'b0100;
        q.push_back(mk(1, 0, 4'b0100, 4'h0, 1, 2, 0, 0));
        tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL single_pulse got %h want %h", obs, exp_v); end
        e1 = 4'b0000;
        tick();
        e1 = 4'b0100;
        q.push_back(mk(2, 0, 4'b0100, 4'h0, 1, 2, 0, 0));
        repeat (5) tick();
        e1 = 4'b0000;
        tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL single_level got %h want %h", obs, exp_v); end
    endtask

    task automatic test_threshold();
        clr = 1'b1;
        q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        tick();
        clr = 1'b0;
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL thr_clear got %h want %h", obs, exp_v); end
        e1 = 4'b1011;
        q.push_back(mk(3, 0, 4'b1011, 4'h0, 1, 0, 0, 1));
        tick();
        e1 = 4'b0000;
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL thr_cross got %h want %h", obs, exp_v); end
        thresh = 16'd0;
        clr = 1'b1;
        q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        tick();
        clr = 1'b0;
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL thr_zero_clear got %h want %h", obs, exp_v); end
        q.push_back(mk(6, 0, 4'b1111, 4'h0, 1, 0, 0, 0));
        e1 = 4'b0001; tick(); e1 = 4'b0000; tick();
        e1 = 4'b0001; tick(); e1 = 4'b0000; tick();
        e1 = 4'b1111; tick(); e1 = 4'b0000; tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL thr_disabled got %h want %h", obs, exp_v); end
        thresh = 16'd5;
        q.push_back(mk(6, 0, 4'b1111, 4'h0, 1, 0, 0, 1));
        tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL thr_lowered got %h want %h", obs, exp_v); end
    endtask

    task automatic test_double_priority();
        thresh = 16'd3;
        clr = 1'b1;
        q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        tick();
        clr = 1'b0;
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL dbl_clear got %h want %h", obs, exp_v); end
        e1 = 4'b1001;
        e2 = 4'b1000;
        q.push_back(mk(1, 1, 4'b0001, 4'b1000, 1, 3, 1, 1));
        tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL dbl_priority got %h want %h", obs, exp_v); end
        e1 = 4'b0000;
        e2 = 4'b0000;
        q.push_back(mk(1, 1, 4'b0001, 4'b1000, 1, 3, 1, 1));
        repeat (2) tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL dbl_alarm_hold got %h want %h", obs, exp_v); end
    endtask

    task automatic test_saturation();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        q.push_back(mk(14, 0, 4'b0001, 4'h0, 1, 0, 0, 1));
        q_small.push_back(4'd14);
        repeat (14) begin e1 = 4'b0001; tick(); e1 = 4'b0000; tick(); end
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_main14 got %h want %h", obs, exp_v); end
        s_exp = q_small.pop_front(); checks++;
        if (s_cnt1 !== s_exp) begin errors++; $display("FAIL sat_small14 got %0d want %0d", s_cnt1, s_exp); end
        q.push_back(mk(20, 0, 4'b0001, 4'h0, 1, 0, 0, 1));
        q_small.push_back(4'd15);
        repeat (6) begin e1 = 4'b0001; tick(); e1 = 4'b0000; tick(); end
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_main20 got %h want %h", obs, exp_v); end
        s_exp = q_small.pop_front(); checks++;
        if (s_cnt1 !== s_exp) begin errors++; $display("FAIL sat_small20 got %0d want %0d", s_cnt1, s_exp); end
    endtask

    task automatic test_clear_collision();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        e1 = 4'b1111; tick(); e1 = 4'b0000; tick();
        e1 = 4'b0001; tick(); e1 = 4'b0000; tick();
        e2 = 4'b0011;
        q.push_back(mk(5, 2, 4'b1111, 4'b0011, 1, 0, 0, 1));
        tick();
        e2 = 4'b0000;
        tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL coll_prior got %h want %h", obs, exp_v); end
        clr = 1'b1;
        e2 = 4'b0010;
        q.push_back(mk(0, 1, 4'h0, 4'b0010, 1, 1, 1, 1));
        tick();
        clr = 1'b0;
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL coll_clear got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_midrun();
        e2 = 4'b0000;
        e1 = 4'b0001;
        #2 rstn = 1'b0;
        q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        #1;
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_async got %h want %h", obs, exp_v); end
        #2 rstn = 1'b1;
        q.push_back(mk(1, 0, 4'b0001, 4'h0, 1, 0, 0, 0));
        tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_release got %h want %h", obs, exp_v); end
        q.push_back(mk(1, 0, 4'b0001, 4'h0, 1, 0, 0, 0));
        repeat (2) tick();
        exp_v = q.pop_front(); obs = sample(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_level_once got %h want %h", obs, exp_v); end
        e1 = 4'b0000;
    endtask

    initial begin
        rstn = 1'b0;
        e1 = '0;
        e2 = '0;
        thresh = 16'd3;
        clr = 1'b0;
        test_reset();
        test_single_event();
        test_threshold();
        test_double_priority();
        test_saturation();
        test_clear_collision();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
